// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources, the register-file write port
// and the read-data path of the register-file arbiter.
interface regfile_wb_arbiter_if #(
    parameter int CW = 16
);
    // Handshake: a source asserts Valid with Addr/Data and keeps all three
    // stable until the cycle in which Ready is also high; that cycle is the
    // transfer. Ready is combinational from this cycle's Valids and the
    // arbiter's own state, and never depends on an earlier Ready.
    logic          AluValid;
    logic [4:0]    AluAddr;
    logic [31:0]   AluData;
    logic          AluReady;

    logic          MemValid;
    logic [4:0]    MemAddr;
    logic [31:0]   MemData;
    logic          MemReady;

    logic [4:0]    Writad;
    logic [31:0]   Writedata;
    logic          RegWr;
    logic [CW-1:0] ConflictCount;

    logic [4:0]    Readad1;
    logic [4:0]    Readad2;
    logic [31:0]   Read1In;
    logic [31:0]   Read2In;
    logic [31:0]   Read1;
    logic [31:0]   Read2;

    modport master (
        output AluValid, AluAddr, AluData,
        input  AluReady,
        output MemValid, MemAddr, MemData,
        input  MemReady,
        input  Writad, Writedata, RegWr, ConflictCount,
        output Readad1, Readad2, Read1In, Read2In,
        input  Read1, Read2
    );

    modport slave (
        input  AluValid, AluAddr, AluData,
        output AluReady,
        input  MemValid, MemAddr, MemData,
        output MemReady,
        output Writad, Writedata, RegWr, ConflictCount,
        input  Readad1, Readad2, Read1In, Read2In,
        output Read1, Read2
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single write-port arbiter for the register file: Mem wins contention unless the
// ALU has waited MAX_WAIT cycles. Optional read bypass under RF_WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int CW       = 16
) (
    input  logic CLK,
    input  logic RESET,
    regfile_wb_arbiter_if.slave bus
);

    localparam int            WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE = WW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WW-1:0] wait_q, wait_d;
    logic [4:0]    writad_q, writad_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          regwr_q, regwr_d;
    logic [CW-1:0] conflict_q, conflict_d;

    logic alu_ready;
    logic mem_ready;
    logic alu_forced;

    always_comb begin
        alu_ready  = 1'b0;
        mem_ready  = 1'b0;
        alu_forced = (wait_q == WAIT_MAX);
        if (!RESET) begin
            if (bus.AluValid && (!bus.MemValid || alu_forced)) begin
                alu_ready = 1'b1;
            end else if (bus.MemValid) begin
                mem_ready = 1'b1;
            end
        end
    end

    always_comb begin
        wait_d     = '0;
        writad_d   = writad_q;
        wdata_d    = wdata_q;
        regwr_d    = 1'b0;
        conflict_d = conflict_q;

        // The refusal counter only survives while the ALU keeps asking and losing.
        if (bus.AluValid && !alu_ready) begin
            wait_d = alu_forced ? wait_q : (wait_q + WAIT_ONE);
        end

        if (alu_ready) begin
            writad_d = bus.AluAddr;
            wdata_d  = bus.AluData;
            regwr_d  = (bus.AluAddr != 5'd0);
        end else if (mem_ready) begin
            writad_d = bus.MemAddr;
            wdata_d  = bus.MemData;
            regwr_d  = (bus.MemAddr != 5'd0);
        end

        if (bus.AluValid && bus.MemValid && !(&conflict_q)) begin
            conflict_d = conflict_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_q     <= '0;
            writad_q   <= '0;
            wdata_q    <= '0;
            regwr_q    <= 1'b0;
            conflict_q <= '0;
        end else begin
            wait_q     <= wait_d;
            writad_q   <= writad_d;
            wdata_q    <= wdata_d;
            regwr_q    <= regwr_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.AluReady      = alu_ready;
    assign bus.MemReady      = mem_ready;
    assign bus.Writad        = writad_q;
    assign bus.Writedata     = wdata_q;
    assign bus.RegWr         = regwr_q;
    assign bus.ConflictCount = conflict_q;

`ifdef RF_WB_BYPASS_EN
    // Register 0 is never forwarded because RegWr is never set for it.
    assign bus.Read1 = (regwr_q && (writad_q == bus.Readad1)) ? wdata_q : bus.Read1In;
    assign bus.Read2 = (regwr_q && (writad_q == bus.Readad2)) ? wdata_q : bus.Read2In;
`else
    logic unused_read_addrs;
    assign unused_read_addrs = ^{bus.Readad1, bus.Readad2};
    assign bus.Read1 = bus.Read1In;
    assign bus.Read2 = bus.Read2In;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32 x 32-bit register file. Two writeback sources, the ALU result path and the memory-load path, compete for the single register-file write port. The block grants one source per cycle with starvation protection and discards writes to register 0. It drives the file's `Writad`/`Writedata`/`RegWr` inputs from registers, and optionally forwards in-flight write data to the read ports.

## Interface
Parameters:
- `MAX_WAIT`, default 3: consecutive cycles the ALU may be refused before it is forced to win (legal range 1..15).
- `CW`, default 16: width of the conflict statistics counter.

Ports:
- `CLK`  in  1  clock; all state updates on posedge.
- `RESET`  in  1  synchronous, active-high reset.
- `AluValid`  in  1  ALU write request.
- `AluAddr`  in  5  ALU destination register.
- `AluData`  in  32  ALU write data.
- `AluReady`  out  1  ALU request accepted this cycle (combinational).
- `MemValid`  in  1  load write request.
- `MemAddr`  in  5  load destination register.
- `MemData`  in  32  load write data.
- `MemReady`  out  1  load request accepted this cycle (combinational).
- `Writad`  out  5  register-file write address (registered).
- `Writedata`  out  32  register-file write data (registered).
- `RegWr`  out  1  register-file write enable (registered).
- `ConflictCount`  out  CW  cycles in which both sources were valid (registered, saturating).
- `Readad1`, `Readad2`  in  5 each  register-file read addresses.
- `Read1In`, `Read2In`  in  32 each  raw register-file read data.
- `Read1`, `Read2`  out  32 each  read data delivered to the datapath.

## Operation
- Handshake: a transfer occurs when Valid and Ready are both high in the same cycle. Ready never depends on an earlier Ready. A source holds Valid, Addr and Data stable until it is accepted.
- Grant rules, evaluated every cycle while RESET is low:
  - MemValid=1, AluValid=0: grant Mem.
  - AluValid=1, MemValid=0: grant Alu.
  - Both valid: grant Mem, unless `WaitCnt == MAX_WAIT`, in which case grant Alu.
  - Neither valid: no grant.
- Exactly one of AluReady and MemReady is high in any cycle with a valid request. Both are low while RESET is high.
- `WaitCnt` is internal and $clog2(MAX_WAIT+1) bits wide:
  - Increments when AluValid=1 and AluReady=0; saturates at MAX_WAIT.
  - Clears when the ALU is accepted or AluValid=0.
- Accepted transfer: on the next posedge the block loads `Writad <= Addr` and `Writedata <= Data`, and sets `RegWr <= (Addr != 0)`. A write to register 0 is accepted but does not assert RegWr.
- No transfer: RegWr <= 0. Writad and Writedata hold their previous values.
- ConflictCount increments when both sources are valid in a cycle, and saturates at all-ones.

## Timing
- Latency from accept to RegWr high is 1 cycle. Throughput is one write per cycle.
- Reset values: RegWr=0, Writad=0, Writedata=0, ConflictCount=0, WaitCnt=0.
- A request presented in the cycle RESET is high is not accepted. It is eligible in the first cycle after RESET falls.
- RESET asserted in the cycle after an accept takes priority: RegWr=0 on the next edge, and the pending write is lost.
- Under continuous contention, the ALU is granted exactly once every MAX_WAIT+1 cycles.

## Configuration
- Macro: `RF_WB_BYPASS_EN`.
- Defined:
  - `Read1 = (RegWr && Writad == Readad1) ? Writedata : Read1In`, and the same for `Read2` with `Readad2` and `Read2In`.
  - The logic is purely combinational.
  - Register 0 is never forwarded, because RegWr is never high for address 0.
- Undefined: `Read1 = Read1In` and `Read2 = Read2In`. The ports are present in both builds.

## Test plan
- Reset, then idle: after RESET falls, RegWr=0, Writad=0, Writedata=0, ConflictCount=0, and both Ready outputs are 0.
- Single ALU write: AluValid=1, AluAddr=11, AluData=32'hDEADBEEF → AluReady=1 the same cycle. The next cycle shows RegWr=1, Writad=11, Writedata=32'hDEADBEEF. The cycle after shows RegWr=0.
- Contention with MAX_WAIT=3, both sources held valid for 8 cycles:
  - Grants are Mem, Mem, Mem, Alu, Mem, Mem, Mem, Alu.
  - ConflictCount=8.
- Register 0 filter: MemValid=1, MemAddr=0 → MemReady=1, and RegWr stays 0 the next cycle.
- Mid-operation reset: accept MemAddr=12, then assert RESET in the next cycle → RegWr=0 after that edge, and all outputs are back at reset values.
- Bypass with `RF_WB_BYPASS_EN` defined:
  - Write reg 13=32'h5, and during the RegWr cycle drive Readad1=13 with Read1In=0. Read1 must be 32'h5.
  - Without the macro, Read1 must be 0.
